muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned mult/div/mod sequencer for the single-cycle core.
// A shift-add multiplier and a restoring divider share one 2*WIDTH accumulator and run one bit per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mod;
  logic               op_valid;
  logic               accept;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;

  // acc = {partial product, remaining multiplier bits}
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] upper;
    upper = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {upper, acc_in[WIDTH-1:1]};
  endfunction

  // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_in,
                                                  input logic [WIDTH-1:0]   d);
    logic [2*WIDTH:0] sh;
    logic [WIDTH:0]   diff;
    sh   = {acc_in, 1'b0};
    diff = sh[2*WIDTH:WIDTH] - {1'b0, d};
    if (diff[WIDTH])
      return sh[2*WIDTH-1:0];
    else
      return {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
  endfunction

  assign op_valid = (op == 4'd2) | (op == 4'd3) | (op == 4'd8);
  assign accept   = start & op_valid & (state == IDLE);
  assign stall    = busy | accept;

  always_comb begin
    acc_nxt = acc;
    case (state)
      MUL:     acc_nxt = mul_step(acc, mcand);
      DIV:     acc_nxt = div_step(acc, divisor);
      default: acc_nxt = acc;
    endcase
  end

  // Datapath: operands and accumulator need no reset, they are loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand   <= a;
      divisor <= b;
      acc     <= (op == 4'd2) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else if (state == MUL || state == DIV) begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_mod      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt         <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            is_mod      <= (op == 4'd8);
            if (op == 4'd2) begin
              state <= MUL;
            end else if (b != '0) begin
              state <= DIV;
            end else begin
              // Divide by zero finishes on the accepting edge.
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              lo          <= '1;
              hi          <= a;
              result      <= (op == 4'd8) ? a : {WIDTH{1'b1}};
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            hi     <= acc_nxt[2*WIDTH-1:WIDTH];
            lo     <= acc_nxt[WIDTH-1:0];
            result <= (state == DIV && is_mod) ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against a plain-arithmetic model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .result(result),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it cycle by cycle until one cycle after done.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit inject);
    logic [63:0]  p;
    logic [W-1:0] e_hi, e_lo, e_res;
    logic         e_dbz;
    int           e_k;
    e_dbz = 1'b0;
    if (o == 4'd2) begin
      p    = {32'b0, x} * {32'b0, y};
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (y == 0) begin
      e_hi  = x;
      e_lo  = '1;
      e_dbz = 1'b1;
    end else begin
      e_hi = x % y;
      e_lo = x / y;
    end
    e_res = (o == 4'd8) ? e_hi : e_lo;
    e_k   = e_dbz ? 0 : W;

    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    chk("req_stall", stall, 1);
    chk("req_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    for (int k = 0; k <= e_k + 1; k++) begin
      @(negedge clk);
      if (inject && k == 3) begin start = 1'b1; op = 4'd2; end
      else start = 1'b0;
      #1;
      chk($sformatf("busy_k%0d", k), busy, k <= e_k);
      chk($sformatf("stall_k%0d", k), stall, k <= e_k);
      chk($sformatf("done_k%0d", k), done, k == e_k);
      if (k >= e_k) begin
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
        chk("result", result, e_res);
        chk("div_by_zero", div_by_zero, e_dbz);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_result", result, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd2, 32'd7, 32'd6, 1'b0);
    do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(4'd3, 32'd100, 32'd7, 1'b0);
    do_op(4'd8, 32'd100, 32'd7, 1'b0);
    do_op(4'd3, 32'h1234, 32'd0, 1'b0);
    do_op(4'd8, 32'h1234, 32'd0, 1'b0);

    // Invalid op: no busy, no stall, outputs untouched.
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd9; b = 32'd9;
    #1;
    chk("inv_stall", stall, 0);
    chk("inv_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("inv_busy2", busy, 0);
    chk("inv_done", done, 0);
    chk("inv_result", result, 32'h1234);
    start = 1'b0;

    // A mult start during a running div is ignored.
    do_op(4'd3, 32'd1000, 32'd33, 1'b1);

    // Reset during iteration 10 of a mult.
    @(negedge clk);
    start = 1'b1; op = 4'd2; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_nodone_%0d", k), done, 0);
    end
    do_op(4'd2, 32'd3, 32'd5, 1'b0);

    // Random ops, with occasional zero/small divisors.
    for (int i = 0; i < 10; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 2))
        0:       ro = 4'd2;
        1:       ro = 4'd3;
        default: ro = 4'd8;
      endcase
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
